// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the two-requester line-memory arbiter.
// State and owner encodings live here so the top and the picker agree on them.
package mem_arb_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker: turns the icache/dcache requests plus the
// preferred owner into a one-hot grant (bit 0 = icache, bit 1 = dcache).
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       ic_req,
    input  logic       dc_req,
    input  owner_t     prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (ic_req && dc_req) begin
            grant = (prio == OWN_IC) ? 2'b01 : 2'b10;
        end else if (ic_req) begin
            grant = 2'b01;
        end else if (dc_req) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache line reads and dcache line reads/writes onto one line RAM.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise dcache wins ties.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_ready_o,
    output logic              ic_err_o,
    output logic [LINE_W-1:0] ic_rdata_o,
    input  logic              dc_req_i,
    input  logic              dc_rw_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic              dc_ready_o,
    output logic              dc_err_o,
    output logic [LINE_W-1:0] dc_rdata_o,
    output logic              mem_valid_o,
    output logic              mem_rw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              dmem_error_i
);

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    owner_t            prio;
    logic              err_flag;
    logic [1:0]        grant;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic [LINE_W-1:0] ic_line;
    logic [LINE_W-1:0] dc_line;

    mem_arb_pick u_pick (
        .ic_req (ic_req_i),
        .dc_req (dc_req_i),
        .prio   (prio),
        .grant  (grant)
    );

`ifdef MEM_ARB_RR_EN
    // Prefer whichever requester was not served by the most recent grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio <= OWN_DC;
        end else if (state == ST_IDLE && grant != 2'b00) begin
            prio <= grant[1] ? OWN_IC : OWN_DC;
        end
    end
`else
    assign prio = OWN_DC;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            owner     <= OWN_IC;
            err_flag  <= 1'b0;
            req_rw    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            ic_line   <= '0;
            dc_line   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && grant != 2'b00) begin
                owner     <= grant[1] ? OWN_DC : OWN_IC;
                req_rw    <= grant[1] ? dc_rw_i : 1'b0;
                req_addr  <= grant[1] ? dc_addr_i : ic_addr_i;
                req_wdata <= grant[1] ? dc_wdata_i : '0;
                err_flag  <= 1'b0;
            end
            // Error wins over ready; only reads overwrite the owner's line.
            if (state == ST_BUSY) begin
                if (dmem_error_i) begin
                    err_flag <= 1'b1;
                end else if (mem_ready_i && !req_rw) begin
                    if (owner == OWN_DC) begin
                        dc_line <= mem_rdata_i;
                    end else begin
                        ic_line <= mem_rdata_i;
                    end
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        mem_valid_o = 1'b0;
        ic_ready_o  = 1'b0;
        ic_err_o    = 1'b0;
        dc_ready_o  = 1'b0;
        dc_err_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                mem_valid_o = 1'b1;
                if (dmem_error_i || mem_ready_i) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                ic_ready_o = (owner == OWN_IC) && !err_flag;
                ic_err_o   = (owner == OWN_IC) && err_flag;
                dc_ready_o = (owner == OWN_DC) && !err_flag;
                dc_err_o   = (owner == OWN_DC) && err_flag;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_rw_o    = req_rw;
    assign mem_addr_o  = req_addr;
    assign mem_wdata_o = req_wdata;
    assign ic_rdata_o  = ic_line;
    assign dc_rdata_o  = dc_line;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a line RAM environment plus a transaction-level
// model of grant order, completion timing, error outcome and per-requester read data.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              ic_req_i = 1'b0;
    logic [ADDR_W-1:0] ic_addr_i = '0;
    logic              ic_ready_o;
    logic              ic_err_o;
    logic [LINE_W-1:0] ic_rdata_o;
    logic              dc_req_i = 1'b0;
    logic              dc_rw_i = 1'b0;
    logic [ADDR_W-1:0] dc_addr_i = '0;
    logic [LINE_W-1:0] dc_wdata_i = '0;
    logic              dc_ready_o;
    logic              dc_err_o;
    logic [LINE_W-1:0] dc_rdata_o;
    logic              mem_valid_o;
    logic              mem_rw_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic [LINE_W-1:0] mem_rdata_i;
    logic              dmem_error_i;

    mem_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ic_req_i     (ic_req_i),
        .ic_addr_i    (ic_addr_i),
        .ic_ready_o   (ic_ready_o),
        .ic_err_o     (ic_err_o),
        .ic_rdata_o   (ic_rdata_o),
        .dc_req_i     (dc_req_i),
        .dc_rw_i      (dc_rw_i),
        .dc_addr_i    (dc_addr_i),
        .dc_wdata_i   (dc_wdata_i),
        .dc_ready_o   (dc_ready_o),
        .dc_err_o     (dc_err_o),
        .dc_rdata_o   (dc_rdata_o),
        .mem_valid_o  (mem_valid_o),
        .mem_rw_o     (mem_rw_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rdata_i  (mem_rdata_i),
        .dmem_error_i (dmem_error_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Line RAM environment: 2048 bytes, 8-byte line stride, ready one cycle after valid.
    bit [LINE_W-1:0] ram [256];
    bit              written [256];
    logic [7:0]      ram_idx;
    logic            ready_r;

    function automatic logic [LINE_W-1:0] init_line(input int unsigned i);
        logic [31:0] w;
        if (i == 8) return {32{8'hA5}};
        w = (i + 32'd1) * 32'h9E37_79B9;
        return {8{w}};
    endfunction

    assign ram_idx      = mem_addr_o[10:3];
    assign dmem_error_i = mem_valid_o && ((mem_addr_o + 64'd8) >= 64'd2048);
    assign mem_ready_i  = ready_r;

    always_comb begin
        mem_rdata_i = '0;
        if (mem_valid_o) mem_rdata_i = written[ram_idx] ? ram[ram_idx] : init_line(ram_idx);
    end

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ready_r <= 1'b0;
        else         ready_r <= mem_valid_o;
    end

    always @(posedge clk_i) begin
        if (mem_valid_o && mem_rw_o && ready_r && !dmem_error_i) begin
            ram[ram_idx]     <= mem_wdata_o;
            written[ram_idx] <= 1'b1;
        end
    end

    // Reference model state.
    typedef struct {
        bit          dc;
        bit          rw;
        logic [63:0] addr;
        logic [255:0] wdata;
    } txn_t;

    logic [LINE_W-1:0] shadow [256];
    logic [LINE_W-1:0] exp_rd [2];
    bit                prefer_dc = 1'b1;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [63:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 64'h7F8;
        if (r == 1) return 64'h1000;
        return 64'($urandom_range(0, 254)) << 3;
    endfunction

    function automatic bit is_err(input logic [63:0] a);
        return (a + 64'd8) >= 64'd2048;
    endfunction

    task automatic run_episode(input bit ic_en, input logic [63:0] ic_a,
                               input bit dc_en, input bit dc_w, input logic [63:0] dc_a,
                               input logic [255:0] dc_d);
        txn_t order[$];
        txn_t t_ic;
        txn_t t_dc;
        txn_t cur;
        int   grant_cyc;
        int   exp_cyc;
        int   vcnt;
        int   budget;
        bit   err;
        bit   ic_p;
        bit   dc_p;
        bit   rdy;
        bit   erp;
        bit   finished;
        int unsigned idx;

        t_ic.dc = 1'b0; t_ic.rw = 1'b0; t_ic.addr = ic_a; t_ic.wdata = '0;
        t_dc.dc = 1'b1; t_dc.rw = dc_w; t_dc.addr = dc_a; t_dc.wdata = dc_w ? dc_d : '0;

        @(negedge clk_i);
        chk("idle_quiet", {mem_valid_o, ic_ready_o, ic_err_o, dc_ready_o, dc_err_o}, 5'b0);

        if (ic_en && dc_en) begin
            if (prefer_dc) begin order.push_back(t_dc); order.push_back(t_ic); end
            else begin order.push_back(t_ic); order.push_back(t_dc); end
        end else if (dc_en) begin
            order.push_back(t_dc);
        end else if (ic_en) begin
            order.push_back(t_ic);
        end
        if (order.size() == 0) return;

        ic_req_i = ic_en; ic_addr_i = ic_a;
        dc_req_i = dc_en; dc_rw_i = dc_w; dc_addr_i = dc_a; dc_wdata_i = dc_d;

        cur = order.pop_front();
        if (RR) prefer_dc = !cur.dc;
        grant_cyc = cyc + 1;
        err = is_err(cur.addr);
        exp_cyc = grant_cyc + (err ? 1 : 2);
        vcnt = 0;
        budget = 0;
        finished = 1'b0;

        while (budget < 40) begin
            @(negedge clk_i);
            budget++;
            if (mem_valid_o) begin
                vcnt++;
                chk("mem_addr", mem_addr_o, cur.addr);
                chk("mem_rw", mem_rw_o, cur.rw);
                if (cur.rw) chk("mem_wdata", mem_wdata_o, cur.wdata);
            end
            ic_p = ic_ready_o | ic_err_o;
            dc_p = dc_ready_o | dc_err_o;
            if (ic_p || dc_p) begin
                chk("pulse_owner", {ic_p, dc_p}, cur.dc ? 2'b01 : 2'b10);
                chk("pulse_cycle", cyc, exp_cyc);
                chk("valid_cycles", vcnt, err ? 1 : 2);
                rdy = cur.dc ? dc_ready_o : ic_ready_o;
                erp = cur.dc ? dc_err_o : ic_err_o;
                chk("pulse_kind", {rdy, erp}, err ? 2'b01 : 2'b10);
                idx = cur.addr[10:3];
                if (!err) begin
                    if (cur.rw) begin
                        shadow[idx] = cur.wdata;
                        chk("ram_write", ram[idx], cur.wdata);
                    end else begin
                        exp_rd[cur.dc] = shadow[idx];
                    end
                end
                chk("ic_rdata", ic_rdata_o, exp_rd[0]);
                chk("dc_rdata", dc_rdata_o, exp_rd[1]);
                if (cur.dc) dc_req_i = 1'b0;
                else        ic_req_i = 1'b0;
                if (order.size() == 0) begin
                    finished = 1'b1;
                    break;
                end
                cur = order.pop_front();
                if (RR) prefer_dc = !cur.dc;
                grant_cyc = cyc + 2;
                err = is_err(cur.addr);
                exp_cyc = grant_cyc + (err ? 1 : 2);
                vcnt = 0;
            end
        end
        chk("episode_done", finished, 1'b1);
        ic_req_i = 1'b0;
        dc_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        for (int i = 0; i < 256; i++) shadow[i] = init_line(i);
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        repeat (3) @(negedge clk_i);
        chk("reset_ctrl", {mem_valid_o, mem_rw_o, ic_ready_o, ic_err_o, dc_ready_o, dc_err_o}, 6'b0);
        chk("reset_addr", mem_addr_o, '0);
        chk("reset_wdata", mem_wdata_o, '0);
        chk("reset_ic_rdata", ic_rdata_o, '0);
        chk("reset_dc_rdata", dc_rdata_o, '0);
        rst_ni = 1'b1;

        // Lone icache read of the 0xA5 line.
        run_episode(1'b1, 64'h40, 1'b0, 1'b0, 64'h0, '0);
        chk("ic_line_a5", ic_rdata_o, {32{8'hA5}});
        chk("dc_untouched", dc_rdata_o, '0);

        // Dcache write, then read it back.
        run_episode(1'b0, 64'h0, 1'b1, 1'b1, 64'h80, 256'h1234);
        chk("dc_rdata_after_wr", dc_rdata_o, '0);
        run_episode(1'b0, 64'h0, 1'b1, 1'b0, 64'h80, '0);
        chk("dc_readback", dc_rdata_o, 256'h1234);

        // Ties, twice in a row.
        run_episode(1'b1, 64'h100, 1'b1, 1'b0, 64'h108, '0);
        run_episode(1'b1, 64'h110, 1'b1, 1'b0, 64'h118, '0);

        // Address error on a dcache read.
        d = dc_rdata_o;
        run_episode(1'b0, 64'h0, 1'b1, 1'b0, 64'h7F8, '0);
        chk("err_rdata_kept", dc_rdata_o, d);

        // Back-to-back icache reads with no gap.
        run_episode(1'b1, 64'h20, 1'b0, 1'b0, 64'h0, '0);
        run_episode(1'b1, 64'h28, 1'b0, 1'b0, 64'h0, '0);

        // Reset while a dcache write is in flight.
        @(negedge clk_i);
        dc_req_i = 1'b1; dc_rw_i = 1'b1; dc_addr_i = 64'h200; dc_wdata_i = rand_line();
        @(negedge clk_i);
        chk("rst_busy_valid", mem_valid_o, 1'b1);
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_mid_ctrl", {mem_valid_o, mem_rw_o, ic_ready_o, ic_err_o, dc_ready_o, dc_err_o}, 6'b0);
        chk("rst_mid_addr", mem_addr_o, '0);
        chk("rst_mid_wdata", mem_wdata_o, '0);
        chk("rst_mid_ic_rdata", ic_rdata_o, '0);
        chk("rst_mid_dc_rdata", dc_rdata_o, '0);
        dc_req_i = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        prefer_dc = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            chk("rst_hold_quiet", {mem_valid_o, ic_ready_o, ic_err_o, dc_ready_o, dc_err_o}, 5'b0);
        end
        rst_ni = 1'b1;
        run_episode(1'b0, 64'h0, 1'b1, 1'b0, 64'h200, '0);
        run_episode(1'b1, 64'h208, 1'b1, 1'b0, 64'h210, '0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            int unsigned mode;
            int unsigned gap;
            mode = $urandom_range(1, 3);
            run_episode(mode[0], rand_addr(), mode[1], 1'($urandom_range(0, 1)), rand_addr(), rand_line());
            gap = $urandom_range(0, 2);
            for (int g = 0; g < int'(gap); g++) begin
                @(negedge clk_i);
                chk("gap_quiet", {mem_valid_o, ic_ready_o, ic_err_o, dc_ready_o, dc_err_o}, 5'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous, active-low:
REQ-002 clk_i  in  1  system clock, all state updates on rising edge.
REQ-003 rst_ni  in  1  asynchronous active-low reset.
REQ-004 ic_req_i  in  1  icache line-read request, level, held until ic_ready_o or ic_err_o.
REQ-005 ic_addr_i  in  64  icache line address.
REQ-006 ic_ready_o  out  1  one-cycle completion pulse to icache.
REQ-007 ic_err_o  out  1  one-cycle error pulse to icache.
REQ-008 ic_rdata_o  out  256  icache read line.
REQ-009 dc_req_i  in  1  dcache request, level, held until dc_ready_o or dc_err_o.
REQ-010 dc_rw_i  in  1  dcache direction, 1 = write, 0 = read.
REQ-011 dc_addr_i  in  64  dcache line address.
REQ-012 dc_wdata_i  in  256  dcache write line.
REQ-013 dc_ready_o / dc_err_o / dc_rdata_o  out  1/1/256  same meaning as icache counterparts.
REQ-014 mem_valid_o, mem_rw_o, mem_addr_o[63:0], mem_wdata_o[255:0]  out  request to line RAM.
REQ-015 mem_ready_i  in  1  RAM ready (registered, one cycle after valid); mem_rdata_i  in  256  RAM data (combinational while valid); dmem_error_i  in  1  RAM address error (combinational).

Function
REQ-016 FSM states SHALL be IDLE, BUSY, DONE; encoding in shared package.
REQ-017 IDLE: if any req, SHALL grant one requester, latch its addr/rw/wdata (icache rw = 0) and owner id, go BUSY; else stay IDLE.
REQ-018 BUSY: mem_valid_o = 1 with latched fields held stable; mem_rw_o/addr/wdata SHALL NOT change during BUSY.
REQ-019 BUSY: on dmem_error_i = 1 SHALL go DONE with error flag set; else on mem_ready_i = 1 SHALL capture mem_rdata_i (reads only) into owner's rdata register, go DONE; error takes priority over ready.
REQ-020 DONE: mem_valid_o = 0; exactly one of owner's ready/err pulses high for this single cycle; next state IDLE unconditionally.
REQ-021 mem_ready_i SHALL be ignored outside BUSY (stale ready after DONE is not a completion).
REQ-022 Read latency, req sampled in IDLE at edge N: BUSY at N+1, ready_i at N+2, ready pulse at N+3.
REQ-023 ic_rdata_o/dc_rdata_o SHALL hold last captured value until next read capture for that requester; writes do not update dc_rdata_o.
REQ-024 Requesters SHALL drop req in the cycle after their pulse; the IDLE cycle guarantees no double-grant.
REQ-025 Request deassertion while BUSY SHALL NOT abort the RAM transaction; DONE pulse still issued.

Reset
REQ-026 On rst_ni low: state IDLE, mem_valid_o = 0, mem_rw_o = 0, mem_addr_o = 0, mem_wdata_o = 0, all ready/err = 0, rdata registers = 0, priority pointer = dcache-preferred.
REQ-027 Reset mid-BUSY SHALL abandon the transaction with no pulse to either requester.

Configuration
REQ-028 Macro MEM_ARB_RR_EN: defined -> round-robin; simultaneous requests granted to the requester not served last; pointer updates on every grant.
REQ-029 Undefined -> fixed priority, dcache always wins ties; pointer logic absent.

Structure
REQ-030 Package mem_arb_pkg SHALL hold state enum, owner id enum (OWN_IC, OWN_DC), LINE_W = 256, ADDR_W = 64.
REQ-031 One sub-module mem_arb_pick: combinational two-way picker (reqs, pointer -> grant one-hot).

Verification
REQ-032 Lone icache read addr 0x40, RAM line 0xA5..A5 -> mem_valid_o high 2 cycles, ic_ready_o pulse at N+3, ic_rdata_o = 0xA5..A5, dc_* idle.
REQ-033 Dcache write addr 0x80 data 0x1234 -> mem_rw_o = 1 throughout BUSY, dc_ready_o pulse, RAM word 0x80 = 0x1234, dc_rdata_o unchanged.
REQ-034 Simultaneous ic/dc reads, fixed priority -> dc served first, ic granted after DONE+IDLE; with MEM_ARB_RR_EN, second tie goes to ic.
REQ-035 Dcache read addr 0x7F8 (addr+8 >= 2048) -> dmem_error_i, dc_err_o pulse, dc_ready_o stays 0, rdata unchanged.
REQ-036 Back-to-back ic requests -> stale mem_ready_i in DONE/IDLE not counted; exactly one ic_ready_o per request.
REQ-037 rst_ni low during BUSY -> all outputs zero immediately, no pulse, next request after release completes normally.
